// File: rtl/fsm_pkg.sv
// fsm_pkg: shared constants for the button conditioner and its debounce channels
package fsm_pkg;

    localparam int DEBOUNCE_DEFAULT = 4;
    localparam int NUM_CH           = 3;
    localparam int CH_B1            = 0;
    localparam int CH_B2            = 1;
    localparam int CH_B3            = 2;
    localparam int SYNC_DEPTH       = 2;

    typedef logic [NUM_CH-1:0] ch_vec_t;

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: one button channel (optional BTN_SYNC_EN synchronizer, debounce counter, press strobe)
module btn_debounce
    import fsm_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic press
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);

    logic          din;
    logic          stable;
    logic [CW-1:0] cnt;
    logic          done;

`ifdef BTN_SYNC_EN
    logic [SYNC_DEPTH-1:0] sync;

    // two-flop synchronizer in front of the debouncer
    always_ff @(posedge clk) begin
        if (reset) sync <= '0;
        else       sync <= {sync[SYNC_DEPTH-2:0], raw};
    end

    assign din = sync[SYNC_DEPTH-1];
`else
    assign din = raw;
`endif

    // the new level is accepted on the edge where the counter is already at its last value
    assign done  = (din != stable) && (cnt == CW'(DEBOUNCE_CYCLES - 1));
    assign press = done && din;

    // counter runs only while the input disagrees with the accepted level
    always_ff @(posedge clk) begin
        if (reset) begin
            stable <= 1'b0;
            cnt    <= '0;
        end else if (din == stable) begin
            cnt    <= '0;
        end else if (done) begin
            stable <= din;
            cnt    <= '0;
        end else begin
            cnt    <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/button_conditioner.sv
// button_conditioner: three debounced buttons serialized into one-cycle press pulses (optional BTN_SYNC_EN)
module button_conditioner
    import fsm_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_b1,
    input  logic raw_b2,
    input  logic raw_b3,
    output logic B1,
    output logic B2,
    output logic B3
);

    ch_vec_t raw;
    ch_vec_t press;
    ch_vec_t pending;
    ch_vec_t grant;

    assign raw[CH_B1] = raw_b1;
    assign raw[CH_B2] = raw_b2;
    assign raw[CH_B3] = raw_b3;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
            .clk   (clk),
            .reset (reset),
            .raw   (raw[i]),
            .press (press[i])
        );
    end

    // fixed priority: B1 over B2 over B3, one grant at a time
    always_comb begin
        grant        = '0;
        grant[CH_B1] = pending[CH_B1];
        grant[CH_B2] = pending[CH_B2] && !pending[CH_B1];
        grant[CH_B3] = pending[CH_B3] && !pending[CH_B1] && !pending[CH_B2];
    end

    // a press already waiting absorbs a repeat; the granted bit is retired on the pulse edge
    always_ff @(posedge clk) begin
        if (reset) begin
            pending <= '0;
            B1      <= 1'b0;
            B2      <= 1'b0;
            B3      <= 1'b0;
        end else begin
            pending <= (pending & ~grant) | press;
            B1      <= grant[CH_B1];
            B2      <= grant[CH_B2];
            B3      <= grant[CH_B3];
        end
    end

endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner: scenario table plus bounce sequence, expected pulses queued per edge
module tb_button_conditioner;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic raw_b1 = 1'b0;
    logic raw_b2 = 1'b0;
    logic raw_b3 = 1'b0;
    logic B1, B2, B3;

    button_conditioner #(.DEBOUNCE_CYCLES(4)) dut (
        .clk    (clk),
        .reset  (reset),
        .raw_b1 (raw_b1),
        .raw_b2 (raw_b2),
        .raw_b3 (raw_b3),
        .B1     (B1),
        .B2     (B2),
        .B3     (B3)
    );

    // free-running clock
    always #5 clk = ~clk;

`ifdef BTN_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    typedef struct {
        string name;
        int    ncyc;
        int    rst;
        int    rise[3];
        int    fall[3];
        int    rise2[3];
        int    p1[3];
        int    p2[3];
    } scen_t;

    scen_t      tbl[10];
    logic [2:0] expq[$];
    int         errors = 0;
    int         checks = 0;

    function automatic int shift(input int p);
        return (p < 0) ? p : p + LAT;
    endfunction

    task automatic step(input logic r, input logic [2:0] raw, input logic [2:0] want, input string tag, input int ed);
        logic [2:0] got;
        logic [2:0] req;
        reset  = r;
        raw_b1 = raw[0];
        raw_b2 = raw[1];
        raw_b3 = raw[2];
        expq.push_back(want);
        @(posedge clk);
        #1;
        got = {B3, B2, B1};
        req = expq.pop_front();
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s edge %0d: B3B2B1=%b expected %b", tag, ed, got, req);
        end
    endtask

    initial begin
        int N[3];
        logic [2:0] raw;
        logic [2:0] want;
        N = '{-1, -1, -1};
        tbl[0] = '{"b3_hold",       10, -1, '{-1, -1,  0}, N,              N,              '{-1, -1,  4}, N};
        tbl[1] = '{"b1_b3",         12, -1, '{ 0, -1,  0}, N,              N,              '{ 4, -1,  5}, N};
        tbl[2] = '{"b2_repress",    34, -1, '{-1,  0, -1}, '{-1, 20, -1}, '{-1, 26, -1}, '{-1,  4, -1}, '{-1, 30, -1}};
        tbl[3] = '{"reset_mid",     14,  3, '{-1,  0, -1}, N,              N,              '{-1,  8, -1}, N};
        tbl[4] = '{"all_three",     12, -1, '{ 0,  0,  0}, N,              N,              '{ 4,  5,  6}, N};
        tbl[5] = '{"stagger",       12, -1, '{ 3,  2, -1}, N,              N,              '{ 7,  6, -1}, N};
        tbl[6] = '{"short3",        10, -1, '{ 0, -1, -1}, '{ 3, -1, -1}, N,              N,              N};
        tbl[7] = '{"exact4",        12, -1, '{ 0, -1, -1}, '{ 4, -1, -1}, N,              '{ 4, -1, -1}, N};
        tbl[8] = '{"short_release", 20, -1, '{-1,  0, -1}, '{-1, 10, -1}, '{-1, 12, -1}, '{-1,  4, -1}, N};
        tbl[9] = '{"reset_pending", 14,  4, '{ 0, -1, -1}, N,              N,              '{ 9, -1, -1}, N};

        for (int s = 0; s < 10; s++) begin
            step(1'b1, 3'b000, 3'b000, "reset", -2);
            step(1'b1, 3'b000, 3'b000, "reset", -1);
            for (int e = 0; e < tbl[s].ncyc; e++) begin
                for (int c = 0; c < 3; c++) begin
                    raw[c]  = (tbl[s].rise[c] >= 0 && e >= tbl[s].rise[c] && (tbl[s].fall[c] < 0 || e < tbl[s].fall[c]))
                           || (tbl[s].rise2[c] >= 0 && e >= tbl[s].rise2[c]);
                    want[c] = (e == shift(tbl[s].p1[c])) || (e == shift(tbl[s].p2[c]));
                end
                step(e == tbl[s].rst, raw, want, tbl[s].name, e);
            end
        end

        step(1'b1, 3'b000, 3'b000, "reset", -2);
        step(1'b1, 3'b000, 3'b000, "reset", -1);
        for (int e = 0; e < 24; e++)
            step(1'b0, {2'b00, (e < 16) && (e % 4 != 3)}, 3'b000, "bounce", e);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/button_conditioner.md
BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
- REQ-001 Parameter DEBOUNCE_CYCLES, default 4: consecutive cycles a raw input must hold a new level before it is accepted; legal range 2..65535.
- REQ-002 clk  input  1  single clock; all logic on rising edge.
- REQ-003 reset  input  1  synchronous, active-high reset.
- REQ-004 raw_b1  input  1  raw, asynchronous, bouncing level of button 1.
- REQ-005 raw_b2  input  1  raw level of button 2.
- REQ-006 raw_b3  input  1  raw level of button 3.
- REQ-007 B1  output  1  registered one-cycle press pulse for button 1; feeds the vending FSM input of the same name.
- REQ-008 B2  output  1  press pulse, button 2.
- REQ-009 B3  output  1  press pulse, button 3.

Function
- REQ-010 Each channel keeps a stable level (reset 0) and a counter of width clog2(DEBOUNCE_CYCLES) (reset 0).
- REQ-011 Edge where the conditioned input equals the stable level: counter cleared to 0.
- REQ-012 Edge where it differs and counter < DEBOUNCE_CYCLES-1: counter increments.
- REQ-013 Edge where it differs and counter == DEBOUNCE_CYCLES-1: stable level takes the input value; counter cleared.
- REQ-014 A stable 0->1 transition sets that channel's pending bit; a 1->0 transition produces no event.
- REQ-015 Pending bit already set when another press is accepted: bit stays set; no second event is queued.
- REQ-016 Every edge: if any pending bit is set, assert exactly one output for one cycle, priority B1 > B2 > B3, and clear that pending bit on the same edge.
- REQ-017 At most one of B1/B2/B3 is high in any cycle; each output is high for exactly one cycle per accepted press.
- REQ-018 Latency without synchronizer: raw level first sampled at edge N and held -> pulse asserted from edge N+DEBOUNCE_CYCLES for one cycle, when no higher-priority channel is pending.
- REQ-019 Simultaneous accepted presses are serialized on consecutive cycles in priority order.
- REQ-020 A button held indefinitely yields one pulse; a new pulse requires an accepted release followed by an accepted press.
- REQ-021 Raw pulses shorter than DEBOUNCE_CYCLES cycles, including bounce trains, produce no output.

Reset
- REQ-022 Reset asserted at any edge clears B1..B3, pending bits, stable levels, counters and synchronizer flops to 0 on that edge; outputs read 0 in the following cycle.
- REQ-023 Reset mid-debounce or with presses pending discards them; a button still held after reset is accepted as a new press after DEBOUNCE_CYCLES cycles.

Configuration
- REQ-024 Macro BTN_SYNC_EN defined: each raw input passes through a two-flop synchronizer before debouncing; latency becomes N+DEBOUNCE_CYCLES+2.
- REQ-025 BTN_SYNC_EN undefined: raw inputs feed the debouncers directly; latency per REQ-018.

Structure
- REQ-026 Shared package fsm_pkg holds the DEBOUNCE_CYCLES default, the channel index constants (B1=0, B2=1, B3=2), and the synchronizer depth constant (2).
- REQ-027 Sub-module btn_debounce implements one channel (synchronizer option, counter, stable level, press-detect strobe) and is instantiated three times; the pending register and priority arbiter reside in button_conditioner.

Verification (DEBOUNCE_CYCLES=4, BTN_SYNC_EN undefined unless stated)
- REQ-028 raw_b3=1 from edge 0 for 10 cycles -> B3=1 only in the cycle after edge 4; B1=B2=0 throughout.
- REQ-029 raw_b1 high for 3 cycles, low for 1 cycle, repeated 4 times -> no output pulse.
- REQ-030 raw_b1 and raw_b3 both rise at edge 0 and are held -> B1 pulses after edge 4 and B3 after edge 5, never both high.
- REQ-031 raw_b2 held high 20 cycles, low 6 cycles, high again -> exactly two B2 pulses, the second 4 edges after re-press.
- REQ-032 raw_b2 high from edge 0, reset=1 at edge 3 only -> no pulse before edge 8; single B2 pulse after edge 8.
- REQ-033 BTN_SYNC_EN defined, raw_b1 high from edge 0 -> B1 pulse after edge 6.
